// File: rtl/flit_sink_pkg.sv
// flit_sink_pkg: shared constants for the flit receiver.
//   CNT_W  - width of the traffic/error counters
//   clog2  - ceiling log2 used to size pointers, levels and counters
`ifndef SIZE
`define SIZE 8
`endif

package flit_sink_pkg;

  localparam int CNT_W = 16;

  // clog2(1) = 0, clog2(2) = 1, clog2(4) = 2, clog2(5) = 3 ...
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/flit_fifo.sv
// flit_fifo: small synchronous FIFO with asynchronous reset.
// Ports:
//   clk, reset       - clock, async active-high reset (pointers/level only)
//   push, wdata      - write one word (caller guarantees not full)
//   pop, rdata       - rdata always shows the head word; pop advances it
//   full, empty      - derived from the occupancy register
//   level            - current occupancy, 0..DEPTH
`ifndef SIZE
`define SIZE 8
`endif

module flit_fifo
  import flit_sink_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic [WIDTH-1:0]   wdata,
  input  logic               pop,
  output logic [WIDTH-1:0]   rdata,
  output logic               full,
  output logic               empty,
  output logic [clog2(DEPTH):0] level
);

  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [LW-1:0]    level_reg;

  // DEPTH is a power of two, so natural pointer overflow wraps modulo DEPTH.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      level_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   level_reg <= level_reg + 1'b1;
        2'b01:   level_reg <= level_reg - 1'b1;
        default: level_reg <= level_reg;
      endcase
    end
  end

  // Storage needs no reset: contents are meaningless once the pointers clear.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_reg] <= wdata;
  end

  // Head word is read directly so a pop can consume it in the same cycle.
  assign rdata = mem[rd_ptr_reg];
  assign full  = (level_reg == LW'(DEPTH));
  assign empty = (level_reg == '0);
  assign level = level_reg;

endmodule

// File: rtl/flit_sink.sv
// flit_sink: terminates a router tx port. Accepts flits over req/ack into a
// FIFO, drains them at one pop per DRAIN_PERIOD cycles and checks the drained
// payloads against an incrementing sequence.
// Ports:
//   clk, reset         - clock, async active-high reset
//   req, data, ack     - sender handshake; ack is a registered 1-cycle pulse
//   rcv_count          - flits drained (wraps)
//   err_count          - sequence mismatches (saturates)
//   last_data          - most recently drained payload
//   level              - FIFO occupancy
//   done               - sticky, rcv_count reached MAX_FLITS
//   overrun            - sticky, a flit drained after done
`ifndef SIZE
`define SIZE 8
`endif

module flit_sink
  import flit_sink_pkg::*;
#(
  parameter int MAX_FLITS    = 16,
  parameter int DEPTH        = 4,
  parameter int DRAIN_PERIOD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  output logic                  ack,
  input  logic [`SIZE-1:0]      data,
  output logic [CNT_W-1:0]      rcv_count,
  output logic [CNT_W-1:0]      err_count,
  output logic [`SIZE-1:0]      last_data,
  output logic [clog2(DEPTH):0] level,
  output logic                  done,
  output logic                  overrun
);

  localparam int DW = clog2(DRAIN_PERIOD) + 1;

  typedef enum logic {ST_IDLE, ST_ACK} state_t;

  state_t            state_reg, state_next;
  logic              accept;
  logic              pop;
  logic              fifo_full;
  logic              fifo_empty;
  logic [`SIZE-1:0]  fifo_rdata;
  logic [DW-1:0]     drain_cnt_reg;
  logic [`SIZE-1:0]  expected_reg;
  logic [CNT_W-1:0]  rcv_count_reg;
  logic [CNT_W-1:0]  rcv_count_next;
  logic [CNT_W-1:0]  err_count_reg;
  logic [`SIZE-1:0]  last_data_reg;
  logic              done_reg;
  logic              overrun_reg;

  flit_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (`SIZE)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (accept),
    .wdata (data),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (level)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= ST_IDLE;
    else       state_reg <= state_next;
  end

  // Only IDLE can accept; the ACK cycle ignores req so a sender that has
  // not yet dropped req is not captured twice.
  always_comb begin
    state_next = state_reg;
    accept     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (req && !fifo_full) begin
          accept     = 1'b1;
          state_next = ST_ACK;
        end
      end
      ST_ACK:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  assign ack = (state_reg == ST_ACK);

  // Free-running rate limiter; pops are only allowed at count 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                                   drain_cnt_reg <= '0;
    else if (drain_cnt_reg == DW'(DRAIN_PERIOD - 1)) drain_cnt_reg <= '0;
    else                                         drain_cnt_reg <= drain_cnt_reg + 1'b1;
  end

  assign pop            = (drain_cnt_reg == '0) && !fifo_empty;
  assign rcv_count_next = rcv_count_reg + 1'b1;

  // Checker resynchronises on every pop, so a single gap costs one error.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      expected_reg  <= '0;
      rcv_count_reg <= '0;
      err_count_reg <= '0;
      last_data_reg <= '0;
      done_reg      <= 1'b0;
      overrun_reg   <= 1'b0;
    end else if (pop) begin
      last_data_reg <= fifo_rdata;
      rcv_count_reg <= rcv_count_next;
      expected_reg  <= fifo_rdata + 1'b1;
      if (fifo_rdata != expected_reg && err_count_reg != {CNT_W{1'b1}})
        err_count_reg <= err_count_reg + 1'b1;
      if (done_reg)
        overrun_reg <= 1'b1;
      if (rcv_count_next == CNT_W'(MAX_FLITS))
        done_reg <= 1'b1;
    end
  end

  assign rcv_count = rcv_count_reg;
  assign err_count = err_count_reg;
  assign last_data = last_data_reg;
  assign done      = done_reg;
  assign overrun   = overrun_reg;

endmodule

// File: tb/tb_flit_sink.sv
// tb_flit_sink: table-driven and hand-sequenced checks of flit_sink with a
// scoreboard of sent payloads compared against drained payloads.
//   dut_a: defaults (DRAIN_PERIOD 1)   dut_b: DRAIN_PERIOD 8   dut_c: MAX_FLITS 2
`ifndef SIZE
`define SIZE 8
`endif

module tb_flit_sink;

  logic clk;
  logic reset;

  logic        req_a, req_b, req_c;
  logic [7:0]  data_a, data_b, data_c;
  logic        ack_a, ack_b, ack_c;
  logic [15:0] rcv_a, rcv_b, rcv_c;
  logic [15:0] err_a, err_b, err_c;
  logic [7:0]  last_a, last_b, last_c;
  logic [2:0]  level_a, level_b, level_c;
  logic        done_a, done_b, done_c;
  logic        ovr_a, ovr_b, ovr_c;

  int checks;
  int errors;
  int cyc;

  logic [7:0] qa[$];
  logic [7:0] qb[$];

  int ack_cyc[16];
  int ack_n;

  logic [15:0] prev_a, prev_b;
  logic        prev_ack_a;
  logic [2:0]  prev_level_b;
  logic [2:0]  max_level_b;
  int          acks_a;

  flit_sink #(.MAX_FLITS(16), .DEPTH(4), .DRAIN_PERIOD(1)) dut_a (
    .clk(clk), .reset(reset), .req(req_a), .ack(ack_a), .data(data_a),
    .rcv_count(rcv_a), .err_count(err_a), .last_data(last_a),
    .level(level_a), .done(done_a), .overrun(ovr_a));

  flit_sink #(.MAX_FLITS(16), .DEPTH(4), .DRAIN_PERIOD(8)) dut_b (
    .clk(clk), .reset(reset), .req(req_b), .ack(ack_b), .data(data_b),
    .rcv_count(rcv_b), .err_count(err_b), .last_data(last_b),
    .level(level_b), .done(done_b), .overrun(ovr_b));

  flit_sink #(.MAX_FLITS(2), .DEPTH(4), .DRAIN_PERIOD(1)) dut_c (
    .clk(clk), .reset(reset), .req(req_c), .ack(ack_c), .data(data_c),
    .rcv_count(rcv_c), .err_count(err_c), .last_data(last_c),
    .level(level_c), .done(done_c), .overrun(ovr_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  function automatic logic get_ack(input int k);
    case (k)
      0:       return ack_a;
      1:       return ack_b;
      default: return ack_c;
    endcase
  endfunction

  function automatic logic [15:0] get_rcv(input int k);
    case (k)
      0:       return rcv_a;
      1:       return rcv_b;
      default: return rcv_c;
    endcase
  endfunction

  // Present a flit and wait for its ack; req is left high so the caller can
  // stream the next flit or drop req at the ack-sampling negedge.
  task automatic send(input int k, input logic [7:0] v);
    bit got;
    case (k)
      0: begin req_a = 1'b1; data_a = v; qa.push_back(v); end
      1: begin req_b = 1'b1; data_b = v; qb.push_back(v); end
      default: begin req_c = 1'b1; data_c = v; end
    endcase
    $display("send dut%0d data=%02h cycle=%0d", k, v, cyc);
    got = 1'b0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (get_ack(k)) got = 1'b1;
    end
    if (!got) timeout("ack_wait");
    else if (k == 0 && ack_n < 16) begin
      ack_cyc[ack_n] = cyc;
      ack_n++;
    end
  endtask

  task automatic wait_rcv(input int k, input logic [15:0] target);
    bit got;
    got = (get_rcv(k) == target);
    for (int n = 0; n < 400 && !got; n++) begin
      @(negedge clk);
      if (get_rcv(k) == target) got = 1'b1;
    end
    if (!got) timeout("rcv_wait");
  endtask

  task automatic reset_all();
    @(negedge clk);
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    reset = 1'b1;
    qa.delete();
    qb.delete();
    ack_n = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Scoreboard and protocol monitor, sampled well after the rising edge.
  always @(posedge clk) begin
    logic [7:0] e;
    #2;
    if (reset) begin
      prev_a       = '0;
      prev_b       = '0;
      prev_ack_a   = 1'b0;
      prev_level_b = '0;
      max_level_b  = '0;
      acks_a       = 0;
    end else begin
      if (rcv_a == prev_a + 16'd1) begin
        if (qa.size() == 0) timeout("sb_a_underflow");
        else begin
          e = qa.pop_front();
          chk("sb_a_data", last_a, e);
        end
      end
      prev_a = rcv_a;
      if (rcv_b == prev_b + 16'd1) begin
        if (qb.size() == 0) timeout("sb_b_underflow");
        else begin
          e = qb.pop_front();
          chk("sb_b_data", last_b, e);
        end
      end
      prev_b = rcv_b;
      if (prev_ack_a) chk("ack_width", ack_a, 1'b0);
      if (ack_a && !prev_ack_a) acks_a++;
      if (prev_level_b == 3'd4) chk("ack_while_full", ack_b, 1'b0);
      if (level_b > max_level_b) max_level_b = level_b;
      prev_ack_a   = ack_a;
      prev_level_b = level_b;
    end
  end

  typedef struct packed {
    logic [3:0][7:0] d;
    logic [15:0]     exp_err;
    logic [7:0]      exp_last;
  } vec_t;

  function automatic vec_t mk(input logic [7:0] d0, d1, d2, d3,
                              input logic [15:0] er, input logic [7:0] la);
    vec_t v;
    v.d[0] = d0; v.d[1] = d1; v.d[2] = d2; v.d[3] = d3;
    v.exp_err = er;
    v.exp_last = la;
    return v;
  endfunction

  vec_t vecs[5];

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    req_a = 1'b0; req_b = 1'b0; req_c = 1'b0;
    data_a = '0; data_b = '0; data_c = '0;
    ack_n = 0;

    vecs[0] = mk(8'd0,   8'd1, 8'd2, 8'd3, 16'd0, 8'd3);
    vecs[1] = mk(8'd0,   8'd1, 8'd3, 8'd4, 16'd1, 8'd4);
    vecs[2] = mk(8'd5,   8'd6, 8'd7, 8'd8, 16'd1, 8'd8);
    vecs[3] = mk(8'd0,   8'd0, 8'd0, 8'd0, 16'd3, 8'd0);
    vecs[4] = mk(8'd255, 8'd0, 8'd1, 8'd2, 16'd1, 8'd2);

    reset_all();
    #1;
    chk("rst_ack",     ack_a,   1'b0);
    chk("rst_rcv",     rcv_a,   16'd0);
    chk("rst_err",     err_a,   16'd0);
    chk("rst_last",    last_a,  8'd0);
    chk("rst_level",   level_a, 3'd0);
    chk("rst_done",    done_a,  1'b0);
    chk("rst_overrun", ovr_a,   1'b0);

    // Table: four streamed flits per row on dut_a.
    for (int r = 0; r < 5; r++) begin
      reset_all();
      for (int i = 0; i < 4; i++) send(0, vecs[r].d[i]);
      req_a = 1'b0;
      wait_rcv(0, 16'd4);
      @(negedge clk);
      chk("tbl_rcv",   rcv_a,   16'd4);
      chk("tbl_err",   err_a,   vecs[r].exp_err);
      chk("tbl_last",  last_a,  vecs[r].exp_last);
      chk("tbl_level", level_a, 3'd0);
      for (int i = 1; i < 4; i++)
        chk("ack_spacing", ack_cyc[i] - ack_cyc[i-1], 32'd2);
      $display("row %0d rcv=%0d err=%0d last=%02h", r, rcv_a, err_a, last_a);
    end

    // Backpressure: slow drain, streaming sender.
    reset_all();
    for (int i = 0; i < 12; i++) send(1, 8'(i));
    req_b = 1'b0;
    wait_rcv(1, 16'd12);
    @(negedge clk);
    chk("bp_rcv",       rcv_b,       16'd12);
    chk("bp_err",       err_b,       16'd0);
    chk("bp_last",      last_b,      8'd11);
    chk("bp_max_level", max_level_b, 3'd4);
    chk("bp_sb_empty",  qb.size(),   32'd0);

    // done / overrun with MAX_FLITS = 2.
    reset_all();
    send(2, 8'd0);
    send(2, 8'd1);
    req_c = 1'b0;
    wait_rcv(2, 16'd2);
    chk("done_set",     done_c, 1'b1);
    chk("ovr_not_yet",  ovr_c,  1'b0);
    send(2, 8'd2);
    req_c = 1'b0;
    wait_rcv(2, 16'd3);
    chk("ovr_set",      ovr_c,  1'b1);
    chk("done_sticky",  done_c, 1'b1);

    // Held req around the ack cycle: one capture only.
    reset_all();
    req_a = 1'b1; data_a = 8'd0; qa.push_back(8'd0);
    begin
      bit got;
      got = 1'b0;
      for (int n = 0; n < 50 && !got; n++) begin
        @(negedge clk);
        if (ack_a) got = 1'b1;
      end
      if (!got) timeout("hold_ack");
    end
    @(negedge clk);
    req_a = 1'b0;
    repeat (6) @(negedge clk);
    chk("hold_rcv",  rcv_a,  16'd1);
    chk("hold_acks", acks_a, 32'd1);

    // Half-cycle asynchronous reset while ack=1 and level=2 on dut_b.
    reset_all();
    send(1, 8'd0);
    send(1, 8'd1);
    chk("pre_ack",   ack_b,   1'b1);
    chk("pre_level", level_b, 3'd2);
    #1;
    reset = 1'b1;
    req_b = 1'b0;
    #1;
    chk("arst_ack",   ack_b,   1'b0);
    chk("arst_level", level_b, 3'd0);
    chk("arst_rcv",   rcv_b,   16'd0);
    chk("arst_last",  last_b,  8'd0);
    chk("arst_done",  done_b,  1'b0);
    #2;
    reset = 1'b0;
    qb.delete();
    send(1, 8'd0);
    req_b = 1'b0;
    wait_rcv(1, 16'd1);
    @(negedge clk);
    chk("post_err",  err_b,  16'd0);
    chk("post_last", last_b, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
